// File: rtl/icache_pkg.sv
// Shared fetch/icache types: block geometry, the fetch-buffer entry layout and
// the fetch FSM states, plus block alignment helpers used by fetch and decode.
package icache_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;

  localparam int RBKSZ     = 4;
  localparam int BLK_BYTES = RBKSZ * 4;
  localparam int BLK_OFF_W = $clog2(RBKSZ);
  localparam int BLK_LSB   = BLK_OFF_W + 2;

  typedef struct packed {
    addr_t                  pc;
    word_t [RBKSZ-1:0]      insts;
    logic  [RBKSZ-1:0]      mask;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_DROP
  } fetch_state_e;

  function automatic addr_t blk_align(addr_t a);
    return {a[31:BLK_LSB], {BLK_LSB{1'b0}}};
  endfunction

  // Slots before the word the PC points at are not part of the fetch.
  function automatic logic [RBKSZ-1:0] slot_mask(addr_t a);
    logic [RBKSZ-1:0]     m;
    logic [BLK_OFF_W-1:0] off;
    off = a[BLK_LSB-1:2];
    for (int i = 0; i < RBKSZ; i++) begin
      m[i] = (BLK_OFF_W'(i) >= off);
    end
    return m;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched blocks toward decode, with a single-cycle flush that
// takes priority over any enqueue or dequeue in the same cycle.
module fetch_buffer
  import icache_pkg::*;
#(
  parameter int  QDEPTH = 4,
  localparam int PW     = $clog2(QDEPTH),
  localparam int CW     = PW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         enq_i,
  input  fetch_entry_t entry_i,
  input  logic         deq_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [QDEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          doEnq, doDeq;

  assign doEnq = enq_i && !flush_i;
  assign doDeq = deq_i && (count_q != '0) && !flush_i;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doEnq) wrPtr_d = wrPtr_q + 1'b1;
      if (doDeq) rdPtr_d = rdPtr_q + 1'b1;
      case ({doEnq, doDeq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doEnq) mem_q[wrPtr_q] <= entry_i;
  end

  assign head_o  = mem_q[rdPtr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

  // The credit check upstream must make this unreachable.
  assert property (@(posedge clk) disable iff (reset)
                   !(enq_i && !flush_i && (count_q == CW'(QDEPTH))));

endmodule

// File: rtl/ifetch_stage.sv
// Fetch stage: owns the PC, issues block-aligned icache requests one at a
// time under a buffer credit, and queues returned blocks toward decode.
module ifetch_stage
  import icache_pkg::*;
#(
  parameter addr_t RESET_PC = 32'h0000_0000,
  parameter int    QDEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid_i,
  input  addr_t             redirect_pc_i,
  output addr_t             ic_addr_o,
  output logic              ic_addr_valid_o,
  input  logic              ic_addr_ready_i,
  input  word_t [RBKSZ-1:0] ic_result_i,
  input  logic              ic_result_valid_i,
  output word_t [RBKSZ-1:0] fb_insts_o,
  output addr_t             fb_pc_o,
  output logic [RBKSZ-1:0]  fb_mask_o,
  output logic              fb_valid_o,
  input  logic              fb_ready_i
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_e  state_q, state_d;
  addr_t         pc_q, pc_d, reqAddr_q, reqAddr_d;
  logic [CW-1:0] count;
  logic          bufValid, accept, enq, deq;
  fetch_entry_t  head, newEntry;

  always_comb begin
    ic_addr_valid_o = 1'b1;
    ic_addr_o       = reqAddr_q;
    if (state_q == FS_REQ) begin
      ic_addr_valid_o = (count < CW'(QDEPTH));
      ic_addr_o       = blk_align(pc_q);
    end
    if (reset) ic_addr_valid_o = 1'b0;
  end

  assign accept = (state_q == FS_REQ) && ic_addr_valid_o && ic_addr_ready_i;

  // reqAddr_q keeps the in-flight address stable even after a redirect
  // overwrites the PC, since the icache needs it held until it answers.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    reqAddr_d = reqAddr_q;
    enq       = 1'b0;
    case (state_q)
      FS_REQ: begin
        if (accept) begin
          state_d   = FS_WAIT;
          reqAddr_d = blk_align(pc_q);
        end
      end
      FS_WAIT: begin
        if (ic_result_valid_i) begin
          enq     = 1'b1;
          pc_d    = reqAddr_q + addr_t'(BLK_BYTES);
          state_d = FS_REQ;
        end
      end
      FS_DROP: begin
        if (ic_result_valid_i) state_d = FS_REQ;
      end
      default: state_d = FS_REQ;
    endcase
    // A result arriving with the redirect retires the outstanding request.
    if (redirect_valid_i) begin
      enq  = 1'b0;
      pc_d = redirect_pc_i;
      if (state_q == FS_REQ) state_d = accept ? FS_DROP : FS_REQ;
      else                   state_d = ic_result_valid_i ? FS_REQ : FS_DROP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FS_REQ;
      pc_q      <= RESET_PC;
      reqAddr_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      reqAddr_q <= reqAddr_d;
    end
  end

  assign newEntry.pc    = reqAddr_q;
  assign newEntry.insts = ic_result_i;
  assign newEntry.mask  = slot_mask(pc_q);
  assign deq            = bufValid && fb_ready_i && !reset;

  fetch_buffer #(.QDEPTH(QDEPTH)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid_i),
    .enq_i   (enq),
    .entry_i (newEntry),
    .deq_i   (deq),
    .head_o  (head),
    .valid_o (bufValid),
    .count_o (count)
  );

  assign fb_valid_o = bufValid && !reset;
  assign fb_pc_o    = head.pc;
  assign fb_insts_o = head.insts;
  assign fb_mask_o  = head.mask;

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: the bench plays the icache and decode, predicts
// fetch addresses and buffered blocks with a queue model, and scoreboards them.
module tb_ifetch_stage;
  import icache_pkg::*;

  localparam addr_t RESET_PC = 32'h0000_0000;
  localparam int    QDEPTH   = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              redirect_valid = 1'b0;
  addr_t             redirect_pc = '0;
  addr_t             ic_addr;
  logic              ic_addr_valid;
  logic              ic_addr_ready = 1'b0;
  word_t [RBKSZ-1:0] ic_result = '0;
  logic              ic_result_valid = 1'b0;
  word_t [RBKSZ-1:0] fb_insts;
  addr_t             fb_pc;
  logic [RBKSZ-1:0]  fb_mask;
  logic              fb_valid;
  logic              fb_ready = 1'b0;

  always #5 clk = ~clk;

  ifetch_stage #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .redirect_valid_i  (redirect_valid),
    .redirect_pc_i     (redirect_pc),
    .ic_addr_o         (ic_addr),
    .ic_addr_valid_o   (ic_addr_valid),
    .ic_addr_ready_i   (ic_addr_ready),
    .ic_result_i       (ic_result),
    .ic_result_valid_i (ic_result_valid),
    .fb_insts_o        (fb_insts),
    .fb_pc_o           (fb_pc),
    .fb_mask_o         (fb_mask),
    .fb_valid_o        (fb_valid),
    .fb_ready_i        (fb_ready)
  );

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: next fetch PC, the one outstanding request, and the
  // expected buffer contents in order.
  addr_t        mPc = RESET_PC;
  addr_t        reqAddr = '0;
  bit           inFlight = 1'b0;
  bit           dropIt = 1'b0;
  int           waitLeft = 0;
  bit           dAccept = 1'b0;
  fetch_entry_t expQ[$];

  int    pReady = 100, pFbReady = 100, pRedirect = 0, pSpurious = 0, pResetPm = 0;
  int    latMin = 0, latMax = 0, pLongMiss = 0;
  bit    forceReset = 1'b0, forceRedirect = 1'b0;
  addr_t forcePc = '0;

  function automatic addr_t alignOf(addr_t a);
    return a - (a % BLK_BYTES);
  endfunction

  function automatic logic [RBKSZ-1:0] expMask(addr_t pc);
    int off  = int'((pc % BLK_BYTES) / 4);
    int full = (1 << RBKSZ) - 1;
    return RBKSZ'(full & ~((1 << off) - 1));
  endfunction

  function automatic word_t [RBKSZ-1:0] blockOf(addr_t a);
    word_t [RBKSZ-1:0] b;
    for (int i = 0; i < RBKSZ; i++) b[i] = (a * 32'd7) ^ (32'hA5A5_0000 + i * 32'h1111);
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: fold the edge just taken into the model, check the request
  // side, then choose inputs for the next edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    if (reset) begin
      mPc = RESET_PC; inFlight = 0; dropIt = 0; expQ.delete();
    end else begin
      if (dAccept) begin
        reqAddr  = alignOf(mPc);
        waitLeft = ($urandom_range(0, 99) < pLongMiss) ? 10 : int'($urandom_range(latMin, latMax));
      end
      if (redirect_valid) begin
        expQ.delete();
        mPc = redirect_pc;
        if (dAccept) begin
          inFlight = 1; dropIt = 1;
        end else if (inFlight && ic_result_valid) begin
          inFlight = 0; dropIt = 0;
        end else if (inFlight) begin
          dropIt = 1;
        end
      end else if (dAccept) begin
        inFlight = 1; dropIt = 0;
      end else if (inFlight && ic_result_valid) begin
        if (!dropIt) begin
          fetch_entry_t e;
          e.pc    = reqAddr;
          e.insts = blockOf(reqAddr);
          e.mask  = expMask(mPc);
          expQ.push_back(e);
          mPc = reqAddr + BLK_BYTES;
        end
        inFlight = 0; dropIt = 0;
      end
    end

    begin
      bit expValid = !reset && (inFlight || expQ.size() < QDEPTH);
      checkOutput("ic_addr_valid", ic_addr_valid, expValid);
      if (expValid) checkOutput("ic_addr", ic_addr, inFlight ? reqAddr : alignOf(mPc));
    end

    reset          = forceReset || ($urandom_range(0, 999) < pResetPm);
    forceReset     = 0;
    redirect_valid = forceRedirect || ($urandom_range(0, 99) < pRedirect);
    if (forceRedirect)                    redirect_pc = forcePc;
    else if ($urandom_range(0, 3) == 0)   redirect_pc = 32'hFFFF_FFF0 + 4 * $urandom_range(0, 3);
    else                                  redirect_pc = $urandom() & ~32'h3;
    forceRedirect  = 0;
    ic_addr_ready  = ($urandom_range(0, 99) < pReady);
    fb_ready       = ($urandom_range(0, 99) < pFbReady);
    if (inFlight) begin
      ic_result_valid = (waitLeft == 0);
      if (waitLeft > 0) waitLeft--;
      ic_result = blockOf(reqAddr);
    end else begin
      ic_result_valid = ($urandom_range(0, 99) < pSpurious);
      ic_result = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    dAccept = !reset && !inFlight && (expQ.size() < QDEPTH) && ic_addr_ready;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // Monitor: on each falling edge compare the head block and pop it when the
  // coming edge will dequeue it.
  always @(negedge clk) begin
    checkOutput("fb_valid", fb_valid, !reset && expQ.size() != 0);
    if (!reset && expQ.size() != 0) begin
      checkOutput("fb_pc", fb_pc, expQ[0].pc);
      checkOutput("fb_insts", fb_insts, expQ[0].insts);
      checkOutput("fb_mask", fb_mask, expQ[0].mask);
      if (fb_ready && !redirect_valid) void'(expQ.pop_front());
    end
  end

  initial begin
    forceReset = 1; applyStimulus();
    forceReset = 1; applyStimulus();
    $display("[TB] streaming hits from reset");
    runCycles(14);

    $display("[TB] redirect to unaligned 0x108");
    forceRedirect = 1; forcePc = 32'h108;
    runCycles(8);

    $display("[TB] ten-cycle miss");
    latMin = 10; latMax = 10;
    runCycles(14);
    latMin = 0; latMax = 0;
    runCycles(4);

    $display("[TB] redirect during a pending miss");
    latMin = 10; latMax = 10;
    for (int i = 0; i < 20 && !inFlight; i++) applyStimulus();
    runCycles(3);
    latMin = 0; latMax = 0;
    forceRedirect = 1; forcePc = 32'h400;
    runCycles(16);

    $display("[TB] decode stalled, buffer fills");
    pFbReady = 0;
    runCycles(16);
    pFbReady = 100; applyStimulus();
    pFbReady = 0;   runCycles(8);
    pFbReady = 100; runCycles(10);

    $display("[TB] PC wrap at top of address space");
    forceRedirect = 1; forcePc = 32'hFFFF_FFF4;
    runCycles(8);

    $display("[TB] reset while waiting on a miss");
    latMin = 5; latMax = 5; pSpurious = 50;
    for (int i = 0; i < 20 && !inFlight; i++) applyStimulus();
    runCycles(2);
    forceReset = 1; applyStimulus();
    latMin = 0; latMax = 0;
    runCycles(12);

    $display("[TB] randomized traffic");
    pReady = 70; pFbReady = 60; pRedirect = 5; pSpurious = 10;
    pResetPm = 3; latMin = 0; latMax = 4; pLongMiss = 10;
    runCycles(3000);

    pRedirect = 0; pResetPm = 0; pFbReady = 100;
    runCycles(20);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
